// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen_pkg
//  Purpose  : Shared defaults and next-PC source encoding for the PC generator
//  Revision : 1.0  initial release
// ============================================================================
package pc_gen_pkg;

  localparam int          DEF_ADDR_W    = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam int          DEF_INC       = 4;
  localparam int          DEF_RAS_DEPTH = 4;

  // Where the next fetch PC comes from, listed in priority order
  typedef enum logic [2:0] {
    SRC_EX   = 3'd0,
    SRC_BR   = 3'd1,
    SRC_HOLD = 3'd2,
    SRC_RET  = 3'd3,
    SRC_SEQ  = 3'd4
  } npc_src_e;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ras
//  Purpose  : Circular return-address stack with saturating occupancy count.
//             A push when full overwrites the oldest entry.
//  Revision : 1.0  initial release
// ============================================================================
module pc_ras #(
  parameter int DEPTH = 4,   // power of two, at least 2
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         replace_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] push_idx;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two
  assign push_idx = top_q + 1'b1;

  assign top_o   = mem_q[top_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

  // Next pointer/count: clear beats push beats pop; replace leaves both alone
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      top_d = '0;
      cnt_d = '0;
    end else if (push_i) begin
      top_d = push_idx;
      if (!full_o) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; never read while empty, so it is left unreset
  always_ff @(posedge clk) begin
    if (!rst && !clear_i) begin
      if (push_i)         mem_q[push_idx] <= data_i;
      else if (replace_i) mem_q[top_q]    <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : Registered fetch-PC generator with exception/branch redirect,
//             stall, and return-address-stack prediction of returns.
//  Revision : 1.0  initial release
// ============================================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int                INC       = DEF_INC,
  parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              ex_redirect_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  input  logic              br_redirect_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ras_empty_o,
  output logic              ras_full_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] ras_top;
  npc_src_e          src;
  logic              ras_push, ras_pop, ras_replace, ras_clear;
  logic              active;

  // Wraps modulo 2^ADDR_W by truncation
  assign seq_pc = pc_q + ADDR_W'(INC);
  assign pc_o   = pc_q;

  // Call/ret only act on cycles that are not redirected or stalled
  assign active = !ex_redirect_i && !br_redirect_i && !stall_i;

  // Next-PC source selection and RAS control
  always_comb begin
    src         = SRC_SEQ;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    ras_clear   = 1'b0;
    if (ex_redirect_i) begin
      src       = SRC_EX;
      ras_clear = 1'b1;
    end else if (br_redirect_i) begin
      src = SRC_BR;
    end else if (stall_i) begin
      src = SRC_HOLD;
    end else if (ret_i && !ras_empty_o) begin
      src         = SRC_RET;
      ras_replace = call_i;
      ras_pop     = !call_i;
    end else begin
      ras_push = call_i && active;
    end
  end

  // Next-PC mux
  always_comb begin
    pc_d = seq_pc;
    unique case (src)
      SRC_EX:   pc_d = ex_target_i;
      SRC_BR:   pc_d = br_target_i;
      SRC_HOLD: pc_d = pc_q;
      SRC_RET:  pc_d = ras_top;
      default:  pc_d = seq_pc;
    endcase
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VEC;
    else     pc_q <= pc_d;
  end

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push_i    (ras_push),
    .pop_i     (ras_pop),
    .replace_i (ras_replace),
    .clear_i   (ras_clear),
    .data_i    (seq_pc),
    .top_o     (ras_top),
    .empty_o   (ras_empty_o),
    .full_o    (ras_full_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Purpose  : Directed self-checking bench for pc_gen with a queue-based
//             reference model and hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        ex_redirect_i = 1'b0;
  logic [31:0] ex_target_i = '0;
  logic        br_redirect_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        call_i = 1'b0;
  logic        ret_i = 1'b0;
  logic [31:0] pc_o;
  logic        ras_empty_o;
  logic        ras_full_o;

  int vectors = 0;
  int errors  = 0;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .ex_redirect_i (ex_redirect_i),
    .ex_target_i   (ex_target_i),
    .br_redirect_i (br_redirect_i),
    .br_target_i   (br_target_i),
    .call_i        (call_i),
    .ret_i         (ret_i),
    .pc_o          (pc_o),
    .ras_empty_o   (ras_empty_o),
    .ras_full_o    (ras_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_valid = 0;

  always @(posedge clk) begin
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (rst) begin
      m_pc = 32'h0;
      m_ras.delete();
      m_valid = 1;
    end else if (ex_redirect_i) begin
      m_pc = ex_target_i;
      m_ras.delete();
    end else if (br_redirect_i) begin
      m_pc = br_target_i;
    end else if (stall_i) begin
      // hold
    end else if (ret_i && m_ras.size() > 0) begin
      m_pc = m_ras[$];
      if (call_i) m_ras[$] = seq;
      else        void'(m_ras.pop_back());
    end else begin
      if (call_i) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = seq;
    end
  end

  // Compare process: every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_pc",    pc_o,               m_pc);
      chk("model_empty", 32'(ras_empty_o),   32'(m_ras.size() == 0));
      chk("model_full",  32'(ras_full_o),    32'(m_ras.size() == DEPTH));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit st, input bit ex, input logic [31:0] ext,
                      input bit br, input logic [31:0] brt, input bit cl, input bit rt);
    stall_i = st; ex_redirect_i = ex; ex_target_i = ext;
    br_redirect_i = br; br_target_i = brt; call_i = cl; ret_i = rt;
    @(posedge clk); #1;
    stall_i = 0; ex_redirect_i = 0; br_redirect_i = 0; call_i = 0; ret_i = 0;
  endtask

  task automatic idle();       step(0,0,0,0,0,0,0); endtask
  task automatic call();       step(0,0,0,0,0,1,0); endtask
  task automatic ret();        step(0,0,0,0,0,0,1); endtask
  task automatic br(input logic [31:0] t); step(0,0,0,1,t,0,0); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset with a push and redirect attempted: reset must win
    rst = 1;
    step(0,1,32'h55,0,0,1,0);
    step(0,0,0,0,0,0,0);
    rst = 0;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_empty", 32'(ras_empty_o), 32'd1);
    chk("rst_full",  32'(ras_full_o),  32'd0);

    // Free running
    idle(); chk("seq1", pc_o, 32'h4);
    idle(); chk("seq2", pc_o, 32'h8);
    idle(); chk("seq3", pc_o, 32'hC);

    // Single call/ret
    br(32'h100); chk("br100", pc_o, 32'h100);
    call();      chk("call_pc", pc_o, 32'h104);
    chk("call_nonempty", 32'(ras_empty_o), 32'd0);
    br(32'h200); chk("br200", pc_o, 32'h200);
    ret();       chk("ret_pc", pc_o, 32'h104);
    chk("ret_empty", 32'(ras_empty_o), 32'd1);

    // Overflow and drain
    br(32'h10);
    for (int i = 0; i < 5; i++) call();
    chk("five_calls_pc", pc_o, 32'h24);
    chk("full", 32'(ras_full_o), 32'd1);
    ret(); chk("ret_a", pc_o, 32'h24);
    chk("not_full", 32'(ras_full_o), 32'd0);
    ret(); chk("ret_b", pc_o, 32'h20);
    ret(); chk("ret_c", pc_o, 32'h1C);
    ret(); chk("ret_d", pc_o, 32'h18);
    chk("drained", 32'(ras_empty_o), 32'd1);
    ret(); chk("ret_empty_seq", pc_o, 32'h1C);
    chk("no_underflow", 32'(ras_empty_o), 32'd1);

    // Stall interactions
    step(1,0,0,1,32'h400,0,0); chk("stall_br", pc_o, 32'h400);
    step(1,0,0,0,0,0,0);       chk("stall_hold", pc_o, 32'h400);
    step(1,0,0,0,0,1,0);       chk("stall_call_hold", pc_o, 32'h400);
    chk("stall_call_noPush", 32'(ras_empty_o), 32'd1);

    // Branch redirect suppresses a call
    step(0,0,0,1,32'h500,1,0); chk("br_call_pc", pc_o, 32'h500);
    chk("br_call_noPush", 32'(ras_empty_o), 32'd1);

    // Exception clears two entries
    call(); call();
    chk("two_calls_pc", pc_o, 32'h508);
    step(0,1,32'h80,1,32'h900,0,0);
    chk("ex_pc", pc_o, 32'h80);
    chk("ex_clear", 32'(ras_empty_o), 32'd1);

    // Call+ret combinations
    call();           chk("cr_push", pc_o, 32'h84);
    step(0,0,0,0,0,1,1); chk("cr_replace_pc", pc_o, 32'h84);
    ret();            chk("cr_ret_new", pc_o, 32'h88);
    chk("cr_empty", 32'(ras_empty_o), 32'd1);
    step(0,0,0,0,0,1,1); chk("cr_empty_seq", pc_o, 32'h8C);
    ret();            chk("cr_empty_pushed", pc_o, 32'h8C);

    // Stalled ret with entries leaves RAS alone
    call();                     // pc 0x90, push 0x90
    step(1,0,0,0,0,0,1);        chk("stall_ret_hold", pc_o, 32'h90);
    chk("stall_ret_keep", 32'(ras_empty_o), 32'd0);

    // Wrap and reset-over-exception
    br(32'hFFFF_FFFC); chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    idle();            chk("wrap", pc_o, 32'h0);
    rst = 1;
    step(0,1,32'h123,0,0,0,0);
    rst = 0;
    chk("rst_over_ex", pc_o, 32'h0);
    chk("rst_over_ex_empty", 32'(ras_empty_o), 32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
